// File: rtl/frac_baud_controller_if.sv
// Control inputs and tick outputs of the fractional baud generator.
interface frac_baud_controller_if;
    logic       enable;
    logic [2:0] baud_select;
    logic       sample_ENABLE;
    logic       tx_ENABLE;
    logic       mid_ENABLE;
    logic       baud_changed;

    modport master (
        output enable, baud_select,
        input  sample_ENABLE, tx_ENABLE, mid_ENABLE, baud_changed
    );

    modport slave (
        input  enable, baud_select,
        output sample_ENABLE, tx_ENABLE, mid_ENABLE, baud_changed
    );
endinterface

// File: rtl/frac_baud_controller.sv
// Phase-accumulator baud generator with oversample, bit and mid-bit ticks.
module frac_baud_controller #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    frac_baud_controller_if.slave  bus
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

    function automatic longint unsigned calc_inc(input longint unsigned baud);
        longint unsigned num;
        num = (64'(OVERSAMPLE) * baud) << ACC_WIDTH;
        return (num + 64'(CLK_FREQ_HZ / 2)) / 64'(CLK_FREQ_HZ);
    endfunction

    localparam longint unsigned INC_TAB [8] = '{
        calc_inc(64'd300),   calc_inc(64'd1200),
        calc_inc(64'd4800),  calc_inc(64'd9600),
        calc_inc(64'd19200), calc_inc(64'd38400),
        calc_inc(64'd57600), calc_inc(64'd115200)
    };

    if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_os
        $error("frac_baud_controller: OVERSAMPLE out of range");
    end
    if (ACC_WIDTH < 16 || ACC_WIDTH > 32) begin : g_bad_aw
        $error("frac_baud_controller: ACC_WIDTH out of range");
    end
    for (genvar g = 0; g < 8; g++) begin : g_chk
        if (INC_TAB[g] == 64'd0 ||
            INC_TAB[g] >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
            $error("frac_baud_controller: increment unusable for code %0d", g);
        end
    end

    typedef enum logic [1:0] {IDLE, RUN, RESYNC} state_e;

    state_e               state_q, state_d;
    logic [2:0]           code_q, code_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sample_q, sample_d;
    logic                 tx_q, tx_d;
    logic                 mid_q, mid_d;

    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH-1:0] sum;
    logic                 carry;

    assign inc = INC_TAB[code_q][ACC_WIDTH-1:0];
    assign {carry, sum} = {1'b0, acc_q} + {1'b0, inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= 3'b000;
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            tx_q     <= 1'b0;
            mid_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            tx_q     <= tx_d;
            mid_q    <= mid_d;
        end
    end

    // A carry on the edge that leaves RUN is dropped, never delivered late.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = 1'b0;
        tx_d     = 1'b0;
        mid_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (bus.baud_select != code_q) begin
                    state_d = RESYNC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    acc_d    = sum;
                    sample_d = carry;
                    if (carry) begin
                        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                        tx_d  = (cnt_q == CNT_LAST);
                        mid_d = (cnt_q == CNT_MID);
                    end
                end
            end
            RESYNC: begin
                code_d  = bus.baud_select;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = bus.enable ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sample_ENABLE = sample_q;
    assign bus.tx_ENABLE     = tx_q;
    assign bus.mid_ENABLE    = mid_q;
    assign bus.baud_changed  = (state_q == RESYNC);
endmodule
